// File: rtl/svga_pixel_pipeline_if.sv
// Signal bundle between the SVGA timing generator / video memories and the pixel pipeline.
// The master side drives counters and memory read data; the slave (pipeline) returns addresses and colour.
interface svga_pixel_pipeline_if;
    logic        blank;
    logic        show_border;
    logic        mode_graph;
    logic        css;
    logic        width_64;
    logic [3:0]  subchar_pixel;
    logic [4:0]  subchar_line;
    logic [6:0]  char_column;
    logic [6:0]  char_line;
    logic [8:0]  graph_pixel;
    logic [9:0]  graph_line_3x;
    logic [10:0] vram_addr;
    logic [7:0]  vram_data;
    logic [9:0]  font_addr;
    logic [7:0]  font_data;
    logic [11:0] rgb;

    modport master (
        output blank, show_border, mode_graph, css, width_64,
        output subchar_pixel, subchar_line, char_column, char_line,
        output graph_pixel, graph_line_3x,
        output vram_data, font_data,
        input  vram_addr, font_addr, rgb
    );

    modport slave (
        input  blank, show_border, mode_graph, css, width_64,
        input  subchar_pixel, subchar_line, char_column, char_line,
        input  graph_pixel, graph_line_3x,
        input  vram_data, font_data,
        output vram_addr, font_addr, rgb
    );
endinterface

// File: rtl/svga_pixel_pipeline.sv
// Free-running SVGA pixel pipeline: counters -> VRAM address -> char code -> font ROM -> pattern -> rgb.
// Counter values sampled on one edge appear on rgb seven edges later; every stage carries its own phase copy.
module svga_pixel_pipeline #(
    parameter int          DECODE_DELAY = 7,
    parameter logic [11:0] BORDER_TEXT  = 12'h000
) (
    input  logic                  pixel_clock,
    input  logic                  reset,
    svga_pixel_pipeline_if.slave  bus
);
    localparam int STAGE_COUNT = DECODE_DELAY;

    typedef struct packed {
        logic [3:0] spx;
        logic [3:0] gpx;
        logic [3:0] sln;
        logic       mode;
        logic       css;
        logic       w64;
    } phase_t;

    phase_t      w_phase_in;
    logic [10:0] w_vram_addr;

    phase_t      r_phase [1:STAGE_COUNT];
    logic [10:0] r_vram_addr_p1;
    logic [7:0]  r_code_p3;
    logic [7:0]  r_code_p4;
    logic [7:0]  r_code_p5;
    logic [9:0]  r_font_addr_p4;
    logic [7:0]  r_pat_p5;
    logic        r_inv_p5;
    logic        r_on_p6;
    logic [1:0]  r_cidx_p6;
    logic [11:0] r_rgb_p7;

    function automatic logic text_bit(input logic [7:0] pat, input logic [3:0] spx, input logic w64);
        logic [2:0] idx;
        idx = w64 ? spx[2:0] : spx[3:1];
        return pat[3'd7 - idx];
    endfunction

    function automatic logic [1:0] graph_index(input logic [7:0] pat, input logic [3:0] gpx);
        logic [1:0] ci;
        case (gpx[3:2])
            2'd0:    ci = pat[7:6];
            2'd1:    ci = pat[5:4];
            2'd2:    ci = pat[3:2];
            default: ci = pat[1:0];
        endcase
        return ci;
    endfunction

    function automatic logic [11:0] palette(input logic mode, input logic css,
                                            input logic on, input logic [1:0] ci);
        logic [11:0] c;
        c = 12'h000;
        if (!mode) begin
            if (on) c = css ? 12'hF80 : 12'h0F0;
        end else begin
            case ({css, ci})
                3'b000:  c = 12'h0F0;
                3'b001:  c = 12'hFF0;
                3'b010:  c = 12'h00F;
                3'b011:  c = 12'hF00;
                3'b100:  c = 12'hFFF;
                3'b101:  c = 12'h0FF;
                3'b110:  c = 12'hF0F;
                default: c = 12'hF80;
            endcase
        end
        return c;
    endfunction

    function automatic logic [11:0] border_colour(input logic mode, input logic css);
        logic [11:0] c;
        if (mode) c = css ? 12'hFFF : 12'h0F0;
        else      c = BORDER_TEXT;
        return c;
    endfunction

    always_comb begin
        w_phase_in      = '0;
        w_phase_in.spx  = bus.subchar_pixel;
        w_phase_in.gpx  = bus.graph_pixel[3:0];
        w_phase_in.sln  = bus.subchar_line[3:0];
        w_phase_in.mode = bus.mode_graph;
        w_phase_in.css  = bus.css;
        w_phase_in.w64  = bus.width_64;
    end

    always_comb begin
        w_vram_addr = '0;
        if (bus.mode_graph)
            w_vram_addr = {bus.graph_line_3x[8:3], bus.graph_pixel[8:4]};
        else if (bus.width_64)
            w_vram_addr = {bus.char_line[4:0], bus.char_column[5:0]};
        else
            w_vram_addr = {2'b00, bus.char_line[3:0], bus.char_column[4:0]};
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= STAGE_COUNT; k++) r_phase[k] <= '0;
            r_vram_addr_p1 <= '0;
            r_code_p3      <= '0;
            r_code_p4      <= '0;
            r_code_p5      <= '0;
            r_font_addr_p4 <= '0;
            r_pat_p5       <= '0;
            r_inv_p5       <= 1'b0;
            r_on_p6        <= 1'b0;
            r_cidx_p6      <= '0;
            r_rgb_p7       <= '0;
        end else begin
            // stage 1: sample counters, register VRAM address
            r_vram_addr_p1 <= w_vram_addr;
            r_phase[1]     <= w_phase_in;
            for (int k = 2; k <= STAGE_COUNT; k++) r_phase[k] <= r_phase[k-1];

            // stage 3: character code; two extra copies line it up with the font ROM data
            r_code_p3 <= bus.vram_data;
            r_code_p4 <= r_code_p3;
            r_code_p5 <= r_code_p4;

            // stage 4: font address, frozen while in graphics mode
            if (!r_phase[3].mode)
                r_font_addr_p4 <= {r_code_p3[5:0], r_phase[3].sln};

            // stage 5: pattern byte and inverse flag
            r_pat_p5 <= r_phase[5].mode ? r_code_p5 : bus.font_data;
            r_inv_p5 <= r_phase[5].mode ? 1'b0 : r_code_p5[6];

            // stage 6: pixel select
            r_on_p6   <= text_bit(r_pat_p5, r_phase[6].spx, r_phase[6].w64) ^ r_inv_p5;
            r_cidx_p6 <= graph_index(r_pat_p5, r_phase[6].gpx);

            // stage 7: palette with blank/border priority; blank and border are already pixel-aligned
            if (bus.blank)
                r_rgb_p7 <= 12'h000;
            else if (bus.show_border)
                r_rgb_p7 <= border_colour(r_phase[7].mode, r_phase[7].css);
            else
                r_rgb_p7 <= palette(r_phase[7].mode, r_phase[7].css, r_on_p6, r_cidx_p6);
        end
    end

    assign bus.vram_addr = r_vram_addr_p1;
    assign bus.font_addr = r_font_addr_p4;
    assign bus.rgb       = r_rgb_p7;
endmodule

// File: tb/tb_svga_pixel_pipeline.sv
// Directed bench for svga_pixel_pipeline with behavioural 1-cycle-latency VRAM and font ROM.
// Per-pixel expectations are queued and compared on rgb eight falling edges after being driven.
module tb_svga_pixel_pipeline;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    svga_pixel_pipeline_if bus();

    svga_pixel_pipeline #(.DECODE_DELAY(7), .BORDER_TEXT(12'h123)) dut (
        .pixel_clock (clk),
        .reset       (rst),
        .bus         (bus)
    );

    logic [7:0] vram [0:2047];
    logic [7:0] font [0:1023];

    always @(posedge clk) begin
        bus.vram_data <= vram[bus.vram_addr];
        bus.font_data <= font[bus.font_addr];
    end

    int n_assert = 0;
    int n_fail   = 0;
    logic [11:0] q_exp [$];
    bit          q_chk [$];
    string       q_tag [$];
    logic [11:0] g_a [0:3];
    logic [11:0] g_b [0:3];
    logic [11:0] t64 [0:7];

    task automatic check(input logic [11:0] obs, input logic [11:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pix(input logic [3:0] spx, input logic [8:0] gpx, input logic cs,
                       input logic [11:0] expv, input bit chk, input string tag);
        logic [11:0] e;
        bit          c;
        string       t;
        @(negedge clk);
        if (q_exp.size() == 8) begin
            e = q_exp.pop_front();
            c = q_chk.pop_front();
            t = q_tag.pop_front();
            if (c) check(bus.rgb, e, t);
        end
        bus.subchar_pixel = spx;
        bus.graph_pixel   = gpx;
        bus.css           = cs;
        q_exp.push_back(expv);
        q_chk.push_back(chk);
        q_tag.push_back(tag);
    endtask

    task automatic flush();
        repeat (8) pix(bus.subchar_pixel, bus.graph_pixel, bus.css, 12'h000, 1'b0, "flush");
        q_exp.delete();
        q_chk.delete();
        q_tag.delete();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) vram[i] = 8'h00;
        for (int i = 0; i < 1024; i++) font[i] = 8'h00;
        vram[11'h045] = 8'h01;
        vram[11'h046] = 8'h41;
        vram[11'h062] = 8'h1B;
        vram[11'h063] = 8'hE4;
        vram[11'h4EA] = 8'h02;
        font[10'h013] = 8'h80;
        font[10'h02C] = 8'hA5;
        g_a[0] = 12'h0F0; g_a[1] = 12'hFF0; g_a[2] = 12'h00F; g_a[3] = 12'hF00;
        g_b[0] = 12'hF00; g_b[1] = 12'h00F; g_b[2] = 12'hFF0; g_b[3] = 12'h0F0;
        t64[0] = 12'h0F0; t64[1] = 12'h000; t64[2] = 12'h0F0; t64[3] = 12'h000;
        t64[4] = 12'h000; t64[5] = 12'h0F0; t64[6] = 12'h000; t64[7] = 12'h0F0;

        rst = 1'b1;
        bus.blank = 1'b0;       bus.show_border = 1'b0;
        bus.mode_graph = 1'b0;  bus.css = 1'b0;          bus.width_64 = 1'b0;
        bus.subchar_pixel = '0; bus.subchar_line = '0;
        bus.char_column = '0;   bus.char_line = '0;
        bus.graph_pixel = '0;   bus.graph_line_3x = '0;

        repeat (3) @(negedge clk);
        check(bus.rgb, 12'h000, "reset_rgb");
        check({1'b0, bus.vram_addr}, 12'h000, "reset_vram_addr");
        check({2'b0, bus.font_addr}, 12'h000, "reset_font_addr");

        // Text 32-column, cell at line 2 column 5
        bus.char_line = 7'd2; bus.char_column = 7'd5; bus.subchar_line = 5'd3;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check({1'b0, bus.vram_addr}, 12'h045, "t32_vram_addr");
        repeat (3) @(negedge clk);
        check({2'b0, bus.font_addr}, 12'h013, "t32_font_addr");
        for (int k = 0; k < 16; k++)
            pix(4'(k), 9'h000, 1'b0, (k < 2) ? 12'h0F0 : 12'h000, 1'b1, $sformatf("t32_px%0d", k));
        flush();

        // Inverse character, css=1
        bus.char_column = 7'd6;
        for (int k = 0; k < 16; k++)
            pix(4'(k), 9'h000, 1'b1, (k < 2) ? 12'h000 : 12'hF80, 1'b1, $sformatf("inv_px%0d", k));
        flush();

        // css flips mid-cell: colour must change on exactly that pixel
        for (int k = 0; k < 16; k++)
            pix(4'(k), 9'h000, (k < 8), (k < 2) ? 12'h000 : ((k < 8) ? 12'hF80 : 12'h0F0),
                1'b1, $sformatf("css_sw_px%0d", k));
        flush();

        // Text 64-column, subchar_line 12
        bus.width_64 = 1'b1; bus.char_line = 7'h13; bus.char_column = 7'h2A; bus.subchar_line = 5'd12;
        bus.css = 1'b0;
        @(negedge clk);
        check({1'b0, bus.vram_addr}, 12'h4EA, "t64_vram_addr");
        for (int k = 0; k < 16; k++)
            pix(4'(k), 9'h000, 1'b0, t64[k % 8], 1'b1, $sformatf("t64_px%0d", k));
        flush();
        check({2'b0, bus.font_addr}, 12'h02C, "t64_font_addr");

        // Address wrap in text mode
        bus.width_64 = 1'b0; bus.char_line = 7'h7F; bus.char_column = 7'h7F;
        @(negedge clk);
        check({1'b0, bus.vram_addr}, 12'h1FF, "t32_wrap_addr");

        // Graphics, two bytes across a phase wrap
        bus.mode_graph = 1'b1; bus.css = 1'b0; bus.graph_line_3x = 10'h018; bus.graph_pixel = 9'h020;
        @(negedge clk);
        check({1'b0, bus.vram_addr}, 12'h062, "gfx_vram_addr");
        for (int k = 0; k < 32; k++)
            pix(4'h0, 9'(9'h020 + k), 1'b0, (k < 16) ? g_a[(k % 16) / 4] : g_b[(k % 16) / 4],
                1'b1, $sformatf("gfx_px%0d", k));
        flush();
        bus.graph_line_3x = 10'h3FF; bus.graph_pixel = 9'h1FF;
        @(negedge clk);
        check({1'b0, bus.vram_addr}, 12'h7FF, "gfx_wrap_addr");
        check({2'b0, bus.font_addr}, 12'h00C, "gfx_font_hold");

        // Single-pixel change appears exactly seven edges after sampling
        bus.mode_graph = 1'b0; bus.css = 1'b0; bus.char_line = 7'd2; bus.char_column = 7'd5;
        bus.subchar_line = 5'd3; bus.subchar_pixel = 4'd0;
        repeat (8) @(negedge clk);
        check(bus.rgb, 12'h0F0, "lat_base");
        bus.subchar_pixel = 4'd2;
        @(negedge clk); bus.subchar_pixel = 4'd0;
        repeat (6) @(negedge clk);
        check(bus.rgb, 12'h0F0, "lat_edge6");
        @(negedge clk);
        check(bus.rgb, 12'h000, "lat_edge7");
        @(negedge clk);
        check(bus.rgb, 12'h0F0, "lat_edge8");

        // Blank over border, then border colours
        bus.mode_graph = 1'b1; bus.css = 1'b1; bus.show_border = 1'b1; bus.blank = 1'b1;
        repeat (9) @(negedge clk);
        check(bus.rgb, 12'h000, "prio_blank");
        bus.blank = 1'b0;
        @(negedge clk);
        check(bus.rgb, 12'hFFF, "prio_border_gfx_css1");
        bus.mode_graph = 1'b0;
        repeat (9) @(negedge clk);
        check(bus.rgb, 12'h123, "prio_border_text");
        bus.show_border = 1'b0;

        // Reset mid-frame
        bus.mode_graph = 1'b1; bus.css = 1'b0; bus.graph_line_3x = 10'h018; bus.graph_pixel = 9'h020;
        repeat (9) @(negedge clk);
        check(bus.rgb, 12'h0F0, "pre_reset_rgb");
        #1 rst = 1'b1;
        #1;
        check(bus.rgb, 12'h000, "async_reset_rgb");
        check({1'b0, bus.vram_addr}, 12'h000, "async_reset_vram_addr");
        @(negedge clk);
        check({1'b0, bus.vram_addr}, 12'h000, "held_reset_vram_addr");
        check({2'b0, bus.font_addr}, 12'h000, "held_reset_font_addr");
        rst = 1'b0;
        repeat (7) @(negedge clk);
        check(bus.rgb, 12'h000, "restart_not_yet");
        @(negedge clk);
        check(bus.rgb, 12'h0F0, "restart_valid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
